// File: rtl/mem_resp.sv
`default_nettype none
// ============================================================================
// mem_resp : LC-3 MIO bus responder (wait states, RAM, KBSR/KBDR/DSR/DDR/MCR).
//            Optional macro DEV_IRQ_EN adds interrupt enables and the irq outputs.
// Revision : 1.0
// ============================================================================
module mem_resp #(
  parameter int AW       = 12,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        dsp_valid,
  output logic [7:0]  dsp_data,
  input  logic        dsp_ready,
  output logic        irq,
  output logic [7:0]  irq_vec,
  output logic [2:0]  irq_pri,
  output logic        halt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]  CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic [15:0] A_KBSR   = 16'hFE00;
  localparam logic [15:0] A_KBDR   = 16'hFE02;
  localparam logic [15:0] A_DSR    = 16'hFE04;
  localparam logic [15:0] A_DDR    = 16'hFE06;
  localparam logic [15:0] A_MCR    = 16'hFFFE;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        commit;
  logic [15:0] lat_addr, lat_wdata;
  logic        lat_rw;
  logic [15:0] acc_addr, acc_wdata;
  logic        acc_rw;
  logic        is_io, wr, rd;
  logic [15:0] rd_val;
  logic        kbsr15, kbsr14, dsr15, dsr14, mcr15;
  logic [7:0]  kbdr;
  logic [15:0] ram [0:(1<<AW)-1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mio_en) begin
          if (WAIT_CYC == 0) begin
            state_nx = S_RESP;
            commit   = 1'b1;
          end else begin
            state_nx = S_WAIT;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = S_RESP;
          commit   = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // A zero-wait access commits on the same edge it is accepted, so use the live bus.
  assign acc_addr  = (state == S_IDLE) ? addr  : lat_addr;
  assign acc_wdata = (state == S_IDLE) ? wdata : lat_wdata;
  assign acc_rw    = (state == S_IDLE) ? r_w   : lat_rw;
  assign is_io     = (acc_addr[15:9] == 7'h7F);
  assign wr        = commit & acc_rw;
  assign rd        = commit & ~acc_rw;
  assign ready     = (state == S_RESP);

  always_comb begin
    rd_val = 16'h0000;
    if (!is_io) begin
      rd_val = ram[acc_addr[AW-1:0]];
    end else begin
      case (acc_addr)
        A_KBSR:  rd_val = {kbsr15, kbsr14, 14'h0};
        A_KBDR:  rd_val = {8'h00, kbdr};
        A_DSR:   rd_val = {dsr15, dsr14, 14'h0};
        A_MCR:   rd_val = {mcr15, 15'h0};
        default: rd_val = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      lat_addr  <= 16'h0000;
      lat_wdata <= 16'h0000;
      lat_rw    <= 1'b0;
      rdata     <= 16'h0000;
      kbsr15    <= 1'b0;
      kbdr      <= 8'h00;
      dsr15     <= 1'b1;
      dsp_valid <= 1'b0;
      dsp_data  <= 8'h00;
      mcr15     <= 1'b1;
      halt      <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && mio_en) begin
        lat_addr  <= addr;
        lat_wdata <= wdata;
        lat_rw    <= r_w;
      end
      if (rd) rdata <= rd_val;
      // A keyboard capture on the same edge as a KBDR read keeps the ready flag set.
      if (kb_valid && !kbsr15) begin
        kbsr15 <= 1'b1;
        kbdr   <= kb_data;
      end else if (rd && acc_addr == A_KBDR) begin
        kbsr15 <= 1'b0;
      end
      if (dsp_valid && dsp_ready) begin
        dsp_valid <= 1'b0;
        dsr15     <= 1'b1;
      end else if (wr && acc_addr == A_DDR && dsr15) begin
        dsp_valid <= 1'b1;
        dsp_data  <= acc_wdata[7:0];
        dsr15     <= 1'b0;
      end
      if (wr && acc_addr == A_MCR) mcr15 <= acc_wdata[15];
      halt <= ~mcr15;
    end
  end

  // Gated by rst_n so an access cut short by reset never lands in RAM.
  always_ff @(posedge clk) begin
    if (wr && !is_io && rst_n) ram[acc_addr[AW-1:0]] <= acc_wdata;
  end

`ifdef DEV_IRQ_EN
  logic kb_irq, ds_irq;
  assign kb_irq = kbsr15 & kbsr14;
  assign ds_irq = dsr15 & dsr14;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbsr14  <= 1'b0;
      dsr14   <= 1'b0;
      irq     <= 1'b0;
      irq_vec <= 8'h00;
      irq_pri <= 3'd0;
    end else begin
      if (wr && acc_addr == A_KBSR) kbsr14 <= acc_wdata[14];
      if (wr && acc_addr == A_DSR)  dsr14  <= acc_wdata[14];
      irq     <= kb_irq | ds_irq;
      irq_vec <= kb_irq ? 8'h80 : (ds_irq ? 8'h81 : 8'h00);
      irq_pri <= (kb_irq | ds_irq) ? 3'd4 : 3'd0;
    end
  end
`else
  assign kbsr14  = 1'b0;
  assign dsr14   = 1'b0;
  assign irq     = 1'b0;
  assign irq_vec = 8'h00;
  assign irq_pri = 3'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_resp.sv
`default_nettype none
// Bench for mem_resp: transaction-level model with per-cycle compare plus directed literal checks.
module tb_mem_resp;

  localparam int WAIT_CYC = 2;
`ifdef DEV_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mio_en, r_w, kb_valid, dsp_ready;
  logic [15:0] addr, wdata, rdata;
  logic [7:0]  kb_data, dsp_data, irq_vec;
  logic        ready, dsp_valid, irq, halt;
  logic [2:0]  irq_pri;

  mem_resp #(.AW(12), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .mio_en(mio_en), .r_w(r_w), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .kb_valid(kb_valid), .kb_data(kb_data),
    .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready),
    .irq(irq), .irq_vec(irq_vec), .irq_pri(irq_pri), .halt(halt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_chk  = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mem_m [int];
  bit          pend, m_ready, m_k15, m_k14, m_d15, m_d14, m_mcr15, m_dv, m_halt, m_irq;
  logic [15:0] m_rdata, p_a, p_d;
  logic [7:0]  m_kbdr, m_dd, m_vec;
  logic [2:0]  m_pri;
  bit          p_rw, rd_kbdr, old_dv, kb_i, ds_i, nr;
  int          cyc, t_commit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 0; m_ready = 0; m_rdata = 16'h0; m_k15 = 0; m_k14 = 0; m_kbdr = 8'h0;
      m_d15 = 1; m_d14 = 0; m_dv = 0; m_dd = 8'h0; m_mcr15 = 1; m_halt = 0;
      m_irq = 0; m_vec = 8'h0; m_pri = 3'd0; cyc = 0;
    end else begin
      kb_i = m_k15 & m_k14;
      ds_i = m_d15 & m_d14;
      m_irq  = IRQ_EN & (kb_i | ds_i);
      m_vec  = !m_irq ? 8'h00 : (kb_i ? 8'h80 : 8'h81);
      m_pri  = m_irq ? 3'd4 : 3'd0;
      m_halt = !m_mcr15;
      old_dv = m_dv;
      rd_kbdr = 0;
      nr = 0;
      if (!pend && !m_ready && mio_en) begin
        pend = 1; t_commit = cyc + WAIT_CYC; p_rw = r_w; p_a = addr; p_d = wdata;
      end
      if (pend && cyc == t_commit) begin
        pend = 0;
        nr = 1;
        if (p_a >= 16'hFE00) begin
          if (p_rw) begin
            if (p_a == 16'hFE00) m_k14 = IRQ_EN & p_d[14];
            if (p_a == 16'hFE04) m_d14 = IRQ_EN & p_d[14];
            if (p_a == 16'hFE06 && m_d15) begin m_dv = 1; m_dd = p_d[7:0]; m_d15 = 0; end
            if (p_a == 16'hFFFE) m_mcr15 = p_d[15];
          end else begin
            m_rdata = 16'h0;
            if (p_a == 16'hFE00) m_rdata = m_k15 ? 16'h8000 : 16'h0;
            if (p_a == 16'hFE00 && m_k14) m_rdata = m_rdata | 16'h4000;
            if (p_a == 16'hFE02) begin m_rdata = {8'h00, m_kbdr}; rd_kbdr = 1; end
            if (p_a == 16'hFE04) m_rdata = (m_d15 ? 16'h8000 : 16'h0) | (m_d14 ? 16'h4000 : 16'h0);
            if (p_a == 16'hFFFE) m_rdata = m_mcr15 ? 16'h8000 : 16'h0;
          end
        end else if (p_rw) begin
          mem_m[int'(p_a % 4096)] = p_d;
        end else begin
          m_rdata = mem_m.exists(int'(p_a % 4096)) ? mem_m[int'(p_a % 4096)] : 16'hxxxx;
        end
      end
      if (kb_valid && !m_k15) begin m_k15 = 1; m_kbdr = kb_data; end
      else if (rd_kbdr) m_k15 = 0;
      if (old_dv && dsp_ready) begin m_dv = 0; m_d15 = 1; end
      m_ready = nr;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("cyc ready", ready, m_ready);
      chk("cyc rdata", rdata, m_rdata);
      chk("cyc dsp_valid", dsp_valid, m_dv);
      chk("cyc dsp_data", dsp_data, m_dd);
      chk("cyc halt", halt, m_halt);
      chk("cyc irq", irq, m_irq);
      chk("cyc irq_vec", irq_vec, m_vec);
      chk("cyc irq_pri", irq_pri, m_pri);
    end
  end

  // ---------------- stimulus ----------------
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int kb_lat, output logic [15:0] rv, output int lat);
    @(negedge clk); #1;
    mio_en = 1; r_w = w; addr = a; wdata = d; lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (ready) break;
      if (lat > 40) begin
        n_checks++; n_fail++;
        $display("FAIL access timeout: addr %h no ready after %0d cycles", a, lat);
        break;
      end
      #1;
      if (lat == 1) begin addr = a ^ 16'h0001; wdata = ~d; r_w = ~w; end
      kb_valid = (lat == kb_lat);
    end
    rv = rdata;
    #1; mio_en = 0; kb_valid = 0; addr = 16'h0; wdata = 16'h0; r_w = 0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] v; int lat;
    access(1'b1, a, d, -1, v, lat);
    chk("write latency", 16'(lat), 16'd3);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] v; int lat;
    access(1'b0, a, 16'h0, -1, v, lat);
    chk({nm, " latency"}, 16'(lat), 16'd3);
    chk(nm, v, exp);
  endtask

  task automatic kb_pulse(input logic [7:0] c);
    @(negedge clk); #1; kb_data = c; kb_valid = 1;
    @(negedge clk); #1; kb_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    int lat;
    bit saw;
    rst_n = 0; mio_en = 0; r_w = 0; addr = 16'h0; wdata = 16'h0;
    kb_valid = 0; kb_data = 8'h0; dsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("reset rdata", rdata, 16'h0);
    chk("reset ready", ready, 16'h0);
    chk("reset dsp_valid", dsp_valid, 16'h0);
    chk("reset dsp_data", dsp_data, 16'h0);
    chk("reset halt", halt, 16'h0);
    chk("reset irq", irq, 16'h0);
    chk("reset irq_vec", irq_vec, 16'h0);
    chk("reset irq_pri", irq_pri, 16'h0);
    #2; rst_n = 1; run_chk = 1;

    // RAM write/read, aliasing, unmapped I/O
    wr(16'h3000, 16'h1234);
    rd_chk("ram x3000", 16'h3000, 16'h1234);
    wr(16'h0005, 16'hABCD);
    rd_chk("ram alias x1005", 16'h1005, 16'hABCD);
    wr(16'hFE10, 16'hFFFF);
    rd_chk("unmapped io", 16'hFE10, 16'h0000);
    rd_chk("ddr reads 0", 16'hFE06, 16'h0000);
    rd_chk("mcr reset", 16'hFFFE, 16'h8000);

    // keyboard
    kb_pulse(8'h41);
    rd_chk("kbsr full", 16'hFE00, 16'h8000);
    kb_pulse(8'h42);
    rd_chk("kbdr first char", 16'hFE02, 16'h0041);
    rd_chk("kbsr cleared", 16'hFE00, 16'h0000);
    kb_data = 8'h5A;
    access(1'b0, 16'hFE02, 16'h0, 2, v, lat);
    chk("kbdr same-edge old", v, 16'h0041);
    rd_chk("kbsr capture wins", 16'hFE00, 16'h8000);
    rd_chk("kbdr new char", 16'hFE02, 16'h005A);
    rd_chk("kbsr cleared 2", 16'hFE00, 16'h0000);

    // display
    wr(16'hFE06, 16'h0048);
    chk("dsp_valid set", dsp_valid, 16'h1);
    chk("dsp_data", dsp_data, 16'h0048);
    rd_chk("dsr busy", 16'hFE04, 16'h0000);
    wr(16'hFE06, 16'h0049);
    chk("ddr dropped", dsp_data, 16'h0048);
    @(negedge clk); #1; dsp_ready = 1;
    @(negedge clk);
    chk("dsp_valid cleared", dsp_valid, 16'h0);
    #1; dsp_ready = 0;
    rd_chk("dsr ready", 16'hFE04, 16'h8000);

    // halt
    wr(16'hFFFE, 16'h0000);
    chk("halt in resp", halt, 16'h0);
    @(negedge clk);
    chk("halt set", halt, 16'h1);
    wr(16'hFFFE, 16'h8000);
    @(negedge clk);
    chk("halt cleared", halt, 16'h0);

    // interrupts
`ifdef DEV_IRQ_EN
    wr(16'hFE00, 16'h4000);
    rd_chk("kbsr ie", 16'hFE00, 16'h4000);
    kb_pulse(8'h43);
    @(negedge clk);
    chk("irq kb", irq, 16'h1);
    chk("irq_vec kb", irq_vec, 16'h0080);
    chk("irq_pri kb", irq_pri, 16'h4);
    rd_chk("kbdr irq char", 16'hFE02, 16'h0043);
    @(negedge clk);
    chk("irq cleared", irq, 16'h0);
    wr(16'hFE00, 16'h0000);
`else
    wr(16'hFE00, 16'h4000);
    rd_chk("kbsr ie not writable", 16'hFE00, 16'h0000);
    kb_pulse(8'h43);
    repeat (2) @(negedge clk);
    chk("irq stays 0", irq, 16'h0);
    rd_chk("kbdr char", 16'hFE02, 16'h0043);
`endif

    // reset during a pending write
    wr(16'h3001, 16'h0BEE);
    @(negedge clk); #1;
    mio_en = 1; r_w = 1; addr = 16'h3001; wdata = 16'h5555;
    @(negedge clk); #1;
    rst_n = 0; mio_en = 0;
    saw = 0;
    repeat (3) begin @(negedge clk); if (ready) saw = 1; end
    #2; rst_n = 1;
    repeat (4) begin @(negedge clk); if (ready) saw = 1; end
    chk("no ready after reset", 16'(saw), 16'h0);
    rd_chk("write discarded", 16'h3001, 16'h0BEE);

    repeat (2) @(negedge clk);
    run_chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
